// File: rtl/fcmp_pkg.sv
// Shared types for the compare-unit scheduler: op codes, FSM states, datapath width.
package fcmp_pkg;

   localparam int FCMP_W = 32;

   typedef enum logic [1:0] {
      OP_LT = 2'b00,
      OP_GT = 2'b01,
      OP_GE = 2'b10,
      OP_NE = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE1,
      WAIT1,
      ISSUE2,
      WAIT2,
      RESP
   } state_e;

   // Final result of a single-issue op; GE is the inverted less-than.
   function automatic logic first_y(op_e op, logic r1);
      return (op == OP_GE) ? ~r1 : r1;
   endfunction

endpackage

// File: rtl/fcmp_sched_if.sv
// Requester and compare-unit handshake bundle for fcmp_sched.
interface fcmp_sched_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]                         req_valid;
   logic [NREQ-1:0]                         req_ready;
   logic [NREQ-1:0][1:0]                    req_op;
   logic [NREQ-1:0][fcmp_pkg::FCMP_W-1:0]   req_x1;
   logic [NREQ-1:0][fcmp_pkg::FCMP_W-1:0]   req_x2;
   logic [NREQ-1:0]                         rsp_valid;
   logic                                    rsp_y;
   logic [NREQ-1:0]                         rsp_ready;
   logic [fcmp_pkg::FCMP_W-1:0]             cu_x1;
   logic [fcmp_pkg::FCMP_W-1:0]             cu_x2;
   logic                                    cu_ready;
   logic                                    cu_valid;
   logic                                    cu_y;

   modport master (
      output req_valid, req_op, req_x1, req_x2, rsp_ready, cu_valid, cu_y,
      input  req_ready, rsp_valid, rsp_y, cu_x1, cu_x2, cu_ready
   );

   modport slave (
      input  req_valid, req_op, req_x1, req_x2, rsp_ready, cu_valid, cu_y,
      output req_ready, rsp_valid, rsp_y, cu_x1, cu_x2, cu_ready
   );
endinterface

// File: rtl/rr_arb.sv
// Combinational round-robin picker: first requester after ptr, wrapping.
module rr_arb #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  idx,
   output logic            any
);
   int             k;
   logic [IDW-1:0] kk;

   // Walk offsets from farthest to nearest so the nearest valid request wins.
   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      k   = 0;
      kk  = '0;
      for (int off = NREQ; off >= 1; off--) begin
         k  = (int'(ptr) + off) % NREQ;
         kk = IDW'(k);
         if (req[kk]) begin
            gnt     = '0;
            gnt[kk] = 1'b1;
            idx     = kk;
            any     = 1'b1;
         end
      end
   end
endmodule

// File: rtl/fcmp_sched.sv
// Shares one less-than compare unit among NREQ requesters, building LT/GT/GE/NE
// from one or two issues with swapped operands and optional inversion.
module fcmp_sched
   import fcmp_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int TMO  = 15,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic        clk,
   input  logic        rstn,
   fcmp_sched_if.slave bus,
   output logic        err
);
   localparam int TW = $clog2(TMO + 1);

   state_e              state_q, state_d;
   logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]      gnt_q, gnt_d;
   op_e                 op_q, op_d;
   logic [FCMP_W-1:0]   a_q, a_d;
   logic [FCMP_W-1:0]   b_q, b_d;
   logic                y_q, y_d;
   logic                err_q, err_d;
   logic [TW-1:0]       tmo_q, tmo_d;

   logic [NREQ-1:0]     arb_gnt;
   logic [IDW-1:0]      arb_idx;
   logic                arb_any;

   logic [NREQ-1:0]     req_ready;
   logic [NREQ-1:0]     rsp_valid;
   logic                rsp_y;
   logic                cu_ready;
   logic                cap;
   logic                first;

   rr_arb #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req (bus.req_valid),
      .ptr (rr_ptr_q),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      gnt_d     = gnt_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      y_d       = y_q;
      err_d     = err_q;
      tmo_d     = tmo_q;
      req_ready = '0;
      rsp_valid = '0;
      rsp_y     = 1'b0;
      cu_ready  = 1'b0;
      cap       = 1'b0;
      first     = (state_q == ISSUE1) || (state_q == WAIT1);

      unique case (state_q)
         IDLE: begin
            // Gated by reset so no accept strobe leaks while rstn is held.
            if (arb_any && !rstn) begin
               req_ready = arb_gnt;
               gnt_d     = arb_idx;
               op_d      = op_e'(bus.req_op[arb_idx]);
               if (bus.req_op[arb_idx] == OP_GT) begin
                  a_d = bus.req_x2[arb_idx];
                  b_d = bus.req_x1[arb_idx];
               end else begin
                  a_d = bus.req_x1[arb_idx];
                  b_d = bus.req_x2[arb_idx];
               end
               state_d = ISSUE1;
            end
         end
         ISSUE1, ISSUE2: begin
            cu_ready = 1'b1;
            tmo_d    = '0;
            if (bus.cu_valid) cap = 1'b1;
            else              state_d = (state_q == ISSUE1) ? WAIT1 : WAIT2;
         end
         WAIT1, WAIT2: begin
            if (bus.cu_valid) begin
               cap = 1'b1;
            end else if (tmo_q == TW'(TMO - 1)) begin
               y_d     = 1'b0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         RESP: begin
            rsp_valid[gnt_q] = 1'b1;
            rsp_y            = y_q;
            if (bus.rsp_ready[gnt_q]) begin
               rr_ptr_d = gnt_q;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // NE needs the swapped compare too; y_q then holds r1 until r2 is OR-ed in.
      if (cap) begin
         if (first && op_q == OP_NE) begin
            y_d     = bus.cu_y;
            a_d     = b_q;
            b_d     = a_q;
            state_d = ISSUE2;
         end else if (first) begin
            y_d     = first_y(op_q, bus.cu_y);
            state_d = RESP;
         end else begin
            y_d     = y_q | bus.cu_y;
            state_d = RESP;
         end
      end
   end

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         state_q  <= IDLE;
         rr_ptr_q <= IDW'(NREQ - 1);
         gnt_q    <= '0;
         op_q     <= OP_LT;
         a_q      <= '0;
         b_q      <= '0;
         y_q      <= 1'b0;
         err_q    <= 1'b0;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         gnt_q    <= gnt_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         y_q      <= y_d;
         err_q    <= err_d;
         tmo_q    <= tmo_d;
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_y     = rsp_y;
   assign bus.cu_ready  = cu_ready;
   assign bus.cu_x1     = a_q;
   assign bus.cu_x2     = b_q;
   assign err           = err_q;

endmodule

// File: tb/tb_fcmp_sched.sv
// Bench for fcmp_sched: directed table, round-robin/timeout/reset sequences,
// and randomized traffic against a float-compare and round-robin reference.
module tb_fcmp_sched;
   import fcmp_pkg::*;

   localparam int NREQ = 4;
   localparam logic [31:0] M1 = 32'hBF800000;  // -1.0
   localparam logic [31:0] P1 = 32'h3F800000;  //  1.0
   localparam logic [31:0] P2 = 32'h40000000;  //  2.0
   localparam logic [31:0] PZ = 32'h00000000;  // +0
   localparam logic [31:0] NZ = 32'h80000000;  // -0
   localparam logic [31:0] PH = 32'h3F000000;  //  0.5

   logic clk  = 1'b0;
   logic rstn = 1'b1;
   logic err;
   int   vectors     = 0;
   int   miscompares = 0;
   int   cu_mode     = 0;   // 0 comb, 1 three-cycle, 2 silent, 3 manual pulse
   logic inj         = 1'b0;
   int   dly_cnt     = 0;
   logic [31:0] ca [2];
   logic [31:0] cb [2];

   fcmp_sched_if #(.NREQ(NREQ)) bus ();

   fcmp_sched #(.NREQ(NREQ), .TMO(15), .IDW(2)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave),
      .err  (err)
   );

   always #5 clk = ~clk;

   function automatic logic flt_lt(logic [31:0] a, logic [31:0] b);
      if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0)) return 1'b0;
      if (a[30:0] == 0 && b[30:0] == 0) return 1'b0;
      if (a[31] != b[31]) return a[31];
      if (!a[31]) return a[30:0] < b[30:0];
      return a[30:0] > b[30:0];
   endfunction

   function automatic logic ref_y(int op, logic [31:0] x1, logic [31:0] x2);
      case (op)
         0:       return flt_lt(x1, x2);
         1:       return flt_lt(x2, x1);
         2:       return !flt_lt(x1, x2);
         default: return flt_lt(x1, x2) || flt_lt(x2, x1);
      endcase
   endfunction

   always @(posedge clk or posedge rstn)
      if (rstn)                             dly_cnt <= 0;
      else if (cu_mode == 1 && bus.cu_ready) dly_cnt <= 3;
      else if (dly_cnt > 0)                  dly_cnt <= dly_cnt - 1;

   always_comb begin
      bus.cu_valid = 1'b0;
      case (cu_mode)
         0:       bus.cu_valid = bus.cu_ready;
         1:       bus.cu_valid = (dly_cnt == 1);
         3:       bus.cu_valid = inj;
         default: bus.cu_valid = 1'b0;
      endcase
      bus.cu_y = flt_lt(bus.cu_x1, bus.cu_x2);
   end

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic expired(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: no DUT event within cycle budget", name);
   endtask

   task automatic drive_req(input int r, input int op, input logic [31:0] x1, input logic [31:0] x2);
      bus.req_op[r]    = 2'(op);
      bus.req_x1[r]    = x1;
      bus.req_x2[r]    = x2;
      bus.req_valid[r] = 1'b1;
   endtask

   task automatic chk_quiet(input string name);
      chk({name, "_ctl"}, {bus.req_ready, bus.rsp_valid, bus.rsp_y, bus.cu_ready, err}, '0);
      chk({name, "_ops"}, {bus.cu_x1, bus.cu_x2}, '0);
   endtask

   // One op end to end: wait for grant, watch issues, hold/accept the response.
   task automatic serve(input int hold, input bit keep, output int g, output logic y,
                        output int lat, output int ncu);
      logic [NREQ-1:0] own;
      g = -1; y = 1'b0; lat = -1; ncu = 0;
      #1;
      for (int k = 0; k < 30 && bus.req_ready == '0; k++) begin
         @(negedge clk); #1;
      end
      if (bus.req_ready == '0) begin expired("grant_wait"); return; end
      for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) g = i;
      chk("req_ready_onehot", $countones(bus.req_ready), 1);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (!keep) bus.req_valid[g] = 1'b0;
         #1;
         if (bus.cu_ready) begin
            if (ncu < 2) begin ca[ncu] = bus.cu_x1; cb[ncu] = bus.cu_x2; end
            ncu++;
         end
         if (bus.rsp_valid != '0) begin lat = k; break; end
      end
      if (lat < 0) begin expired("rsp_wait"); return; end
      own = '0;
      own[g] = 1'b1;
      chk("rsp_owner", bus.rsp_valid, own);
      y = bus.rsp_y;
      bus.rsp_ready = ~own;   // non-owners saying ready must not release it
      for (int h = 0; h < hold; h++) begin
         @(negedge clk); #1;
         chk("rsp_hold", {bus.rsp_valid, bus.rsp_y, bus.req_ready}, {own, y, {NREQ{1'b0}}});
      end
      bus.rsp_ready = own;
      @(negedge clk);
      bus.rsp_ready = '0;
      #1 chk("rsp_release", bus.rsp_valid, '0);
   endtask

   typedef struct {
      int          r;
      int          op;
      logic [31:0] x1;
      logic [31:0] x2;
      logic        y;
      int          ncu;
      int          lat;
      logic [31:0] a0;
      logic [31:0] b0;
   } vec_t;

   vec_t        tbl [9];
   logic [31:0] pool [6];
   int          rop [NREQ];
   logic [31:0] rx1 [NREQ];
   logic [31:0] rx2 [NREQ];

   function automatic logic [31:0] rnd_val();
      if ($urandom_range(0, 3) == 0) return $urandom;
      return pool[$urandom_range(0, 5)];
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int   g, lat, ncu, eg, p;
      logic y;
      logic [NREQ-1:0] pend;

      pool = '{M1, P1, P2, PZ, NZ, PH};
      tbl[0] = '{0, 0, M1, P1, 1'b1, 1, 2, M1, P1};
      tbl[1] = '{1, 1, P2, P1, 1'b1, 1, 2, P1, P2};
      tbl[2] = '{1, 2, P2, P1, 1'b1, 1, 2, P2, P1};
      tbl[3] = '{2, 3, P1, P1, 1'b0, 2, 3, P1, P1};
      tbl[4] = '{3, 3, P1, P2, 1'b1, 2, 3, P1, P2};
      tbl[5] = '{0, 2, P1, P1, 1'b1, 1, 2, P1, P1};
      tbl[6] = '{2, 0, P1, M1, 1'b0, 1, 2, P1, M1};
      tbl[7] = '{3, 1, NZ, PZ, 1'b0, 1, 2, PZ, NZ};
      tbl[8] = '{1, 3, PH, M1, 1'b1, 2, 3, PH, M1};

      bus.req_valid = '0;
      bus.req_op    = '0;
      bus.req_x1    = '0;
      bus.req_x2    = '0;
      bus.rsp_ready = '0;

      repeat (2) @(negedge clk);
      #1 chk_quiet("reset");
      @(negedge clk);
      rstn = 1'b0;

      // Directed table, combinational compare unit.
      cu_mode = 0;
      foreach (tbl[n]) begin
         drive_req(tbl[n].r, tbl[n].op, tbl[n].x1, tbl[n].x2);
         serve(0, 1'b0, g, y, lat, ncu);
         chk($sformatf("tbl%0d_grant", n), g, tbl[n].r);
         chk($sformatf("tbl%0d_y", n), y, tbl[n].y);
         chk($sformatf("tbl%0d_ncu", n), ncu, tbl[n].ncu);
         chk($sformatf("tbl%0d_lat", n), lat, tbl[n].lat);
         chk($sformatf("tbl%0d_issue1", n), {ca[0], cb[0]}, {tbl[n].a0, tbl[n].b0});
         if (tbl[n].op == 3)
            chk($sformatf("tbl%0d_issue2", n), {ca[1], cb[1]}, {tbl[n].x2, tbl[n].x1});
      end

      // Round robin with all requesters holding valid from reset.
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         rop[i] = $urandom_range(0, 3); rx1[i] = rnd_val(); rx2[i] = rnd_val();
         drive_req(i, rop[i], rx1[i], rx2[i]);
      end
      #1 chk("rst_no_accept", bus.req_ready, '0);
      @(negedge clk);
      rstn = 1'b0;
      for (int n = 0; n < 5; n++) begin
         serve((n % NREQ == 2) ? 5 : 0, 1'b1, g, y, lat, ncu);
         chk($sformatf("rr%0d_grant", n), g, n % NREQ);
         chk($sformatf("rr%0d_y", n), y, ref_y(rop[n % NREQ], rx1[n % NREQ], rx2[n % NREQ]));
      end
      bus.req_valid = '0;

      // Timeout, then a stray cu_valid while idle.
      cu_mode = 2;
      drive_req(0, 0, M1, P1);
      serve(0, 1'b0, g, y, lat, ncu);
      chk("tmo_lat", lat, 17);
      chk("tmo_y", y, 1'b0);
      chk("tmo_ncu", ncu, 1);
      chk("tmo_err", err, 1'b1);
      cu_mode = 3;
      inj = 1'b1;
      #1 chk("late_valid", {bus.req_ready, bus.rsp_valid, bus.cu_ready, err}, {{(2*NREQ+1){1'b0}}, 1'b1});
      @(negedge clk);
      inj = 1'b0;
      repeat (3) begin
         #1 chk("late_idle", {bus.req_ready, bus.rsp_valid, bus.cu_ready, err}, {{(2*NREQ+1){1'b0}}, 1'b1});
         @(negedge clk);
      end
      cu_mode = 0;
      drive_req(3, 0, M1, P1);
      serve(0, 1'b0, g, y, lat, ncu);
      chk("post_tmo_y", {y, lat[3:0]}, {1'b1, 4'd2});
      chk("err_sticky", err, 1'b1);

      // Async reset while waiting on a slow unit.
      drive_req(0, 1, P2, P1);
      serve(0, 1'b0, g, y, lat, ncu);
      chk("pre_rst_grant", g, 0);
      cu_mode = 1;
      drive_req(1, 0, M1, P1);
      #1 chk("slow_accept", bus.req_ready, 4'b0010);
      @(negedge clk);
      bus.req_valid = '0;
      #1 chk("slow_issue", bus.cu_ready, 1'b1);
      @(negedge clk); #1;
      chk("slow_wait", {bus.cu_ready, bus.rsp_valid}, '0);
      rstn = 1'b1;
      #1 chk_quiet("mid_rst");
      drive_req(0, 0, M1, P1);
      drive_req(1, 2, M1, P1);
      @(negedge clk);
      rstn = 1'b0;
      serve(0, 1'b0, g, y, lat, ncu);
      chk("after_rst_grant", g, 0);
      chk("slow_lat", lat, 5);
      chk("slow_y", y, 1'b1);
      cu_mode = 0;
      serve(0, 1'b0, g, y, lat, ncu);
      chk("after_rst_next", {g[3:0], y}, {4'd1, 1'b0});
      bus.req_valid = '0;

      // Randomized traffic against the reference model.
      @(negedge clk); rstn = 1'b1;
      repeat (2) @(negedge clk);
      rstn = 1'b0;
      p = NREQ - 1;
      pend = '0;
      for (int it = 0; it < 40; it++) begin
         if (pend == '0) begin
            pend = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++)
               if (pend[i]) begin
                  rop[i] = $urandom_range(0, 3); rx1[i] = rnd_val(); rx2[i] = rnd_val();
                  drive_req(i, rop[i], rx1[i], rx2[i]);
               end
         end
         eg = -1;
         for (int off = NREQ; off >= 1; off--)
            if (pend[(p + off) % NREQ]) eg = (p + off) % NREQ;
         serve($urandom_range(0, 2), 1'b0, g, y, lat, ncu);
         chk($sformatf("rnd%0d_grant", it), g, eg);
         chk($sformatf("rnd%0d_y", it), y, ref_y(rop[eg], rx1[eg], rx2[eg]));
         chk($sformatf("rnd%0d_lat", it), {lat[3:0], ncu[3:0]},
             (rop[eg] == 3) ? {4'd3, 4'd2} : {4'd2, 4'd1});
         p = eg;
         pend[eg] = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fcmp_sched.md
Name: fcmp_sched

Overview:
- Shares one FPU "less-than" compare unit (predicate P(a,b), ready/valid handshake, single- or multi-cycle) among NREQ requesters.
- Round-robin arbitration between requesters.
- Builds LT/GT/GE/NE results by issuing the unit once or twice, with operands swapped and/or the result inverted.
- Routes each result back to the requester that issued the op.
- Sits between the FPU issue logic and the shared compare datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
TMO, 15, max cycles to wait for cu_valid after an issue before declaring a timeout
IDW, 2, width of the grant index ($clog2(NREQ))

Ports:
clk  in  1  clock
rstn  in  1  reset; asynchronous, active-high (1 = reset)
req_valid  in  NREQ  per-requester op request
req_ready  out  NREQ  per-requester accept strobe (one-hot, one cycle)
req_op  in  2*NREQ  op code per requester: 00 LT, 01 GT, 10 GE, 11 NE
req_x1  in  32*NREQ  operand 1 per requester
req_x2  in  32*NREQ  operand 2 per requester
rsp_valid  out  NREQ  result valid to the owning requester
rsp_y  out  1  result bit, meaningful only while rsp_valid != 0
rsp_ready  in  NREQ  requester accepts result
cu_x1  out  32  compare-unit operand a
cu_x2  out  32  compare-unit operand b
cu_ready  out  1  compare-unit start strobe
cu_valid  in  1  compare-unit result valid; may assert in the same cycle as cu_ready
cu_y  in  1  compare-unit result P(a,b)
err  out  1  sticky timeout flag

Behaviour:
- Reset: state=IDLE, rr_ptr=NREQ-1 (requester 0 has first priority).
- Reset values: req_ready=0, rsp_valid=0, rsp_y=0, cu_ready=0, cu_x1=0, cu_x2=0, err=0, timeout counter=0.
- Reset asserted mid-operation aborts the op. No response is delivered and the request is not re-accepted automatically.
- FSM states: IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, RESP.
- IDLE:
  - g = first i with req_valid[i], searching (rr_ptr+1) mod NREQ upward with wrap.
  - Pulse req_ready[g] for one cycle; latch x1, x2, op and g; go ISSUE1.
  - If no request, stay in IDLE.
- Operand order for the first issue:
  - LT, GE, NE: (a,b) = (x1,x2).
  - GT: (a,b) = (x2,x1).
- ISSUE1: drive cu_x1/cu_x2 and pulse cu_ready for 1 cycle, then go WAIT1.
  - If cu_valid=1 in the same cycle, capture cu_y as r1 and skip WAIT1.
  - The skip goes to ISSUE2 if op=NE, otherwise to RESP.
- WAIT1: hold cu_x1/cu_x2 stable and count cycles.
  - On cu_valid: capture r1; go to ISSUE2 (NE) or RESP.
- ISSUE2 / WAIT2 (NE only): same as ISSUE1/WAIT1 with (a,b) = (x2,x1); capture r2.
- Result bit:
  - LT, GT: y = r1.
  - GE: y = ~r1.
  - NE: y = r1 | r2.
- Timeout: if TMO cycles elapse in WAIT1/WAIT2 without cu_valid:
  - force that result to 0, set err=1 and go to RESP.
  - err stays 1 until reset.
  - A late cu_valid arriving outside a WAIT state is ignored.
- RESP: rsp_valid[g]=1 and rsp_y=y, held stable until rsp_ready[g]=1.
  - On that cycle: rsp_valid returns to 0, rr_ptr=g, next state IDLE.
  - rsp_ready of non-owner requesters is ignored.
- Only one op is in flight; the compare unit never sees cu_ready while an issue is outstanding.
- Minimum latency, accept to rsp_valid: 2 cycles for a single-issue op with combinational unit; 3 cycles for NE.
- Fairness: a requester that holds req_valid is granted within NREQ ops.

Decomposition:
- Package fcmp_pkg:
  - op enum (OP_LT, OP_GT, OP_GE, OP_NE);
  - state enum;
  - constant FCMP_W=32.
- Sub-module rr_arb (NREQ requests + pointer -> one-hot grant + index), purely combinational.
- The rest (FSM, operand/result registers, timeout counter) stays in fcmp_sched.

Test Plan:
- Single LT, combinational model (cu_valid=cu_ready), with P = IEEE less-than:
  - stimulus: req0 op=LT, x1=0xBF800000 (-1.0), x2=0x3F800000 (1.0);
  - response: req_ready[0] pulse, one cu_ready, rsp_valid[0] with rsp_y=1 two cycles after accept.
- GT/GE with operand swap:
  - stimulus: req1 GT, x1=0x40000000 (2.0), x2=0x3F800000 (1.0);
  - response: cu_x1=0x3F800000, cu_x2=0x40000000, y=1.
  - stimulus: GE of the same operands; response: y=1.
- NE on equal operands:
  - stimulus: x1=x2=0x3F800000;
  - response: exactly two cu_ready pulses with swapped operands, y=0.
  - stimulus: x1=0x3F800000, x2=0x40000000; response: y=1.
- Round-robin:
  - stimulus: all 4 requesters hold req_valid from reset;
  - response: grants 0,1,2,3,0 in order.
  - stimulus: rsp_ready[2] held low 5 cycles;
  - response: rsp_valid[2] held stable for those cycles, no new grant.
- Timeout:
  - stimulus: cu_valid never asserted;
  - response: after 15 WAIT cycles rsp_valid with y=0, err=1 and it stays 1.
  - stimulus: a later cu_valid pulse in IDLE; response: no effect.
- Async reset in WAIT1 with multi-cycle unit (cu_valid 3 cycles after cu_ready):
  - response: immediately all outputs 0, state IDLE, requester 0 granted first after release.
